// File: rtl/jtpopeye_pkg.sv
// Shared types and defaults for the jtpopeye bus arbitration logic.
package jtpopeye_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int AW_DEF = 10;

endpackage

// File: rtl/jtpopeye_busarb.sv
// Object-RAM bus arbiter between the Z80 core and the object DMA.
// Drains any CPU memory cycle, grants the bus, muxes the RAM to the DMA,
// and registers DMA read data.
module jtpopeye_busarb
  import jtpopeye_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DRAIN_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          busrq_n,
  output logic          busak_n,
  input  logic          cpu_mreq_n,
  input  logic          cpu_ram_cs,
  input  logic          cpu_wr_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic          cpu_busrq_n,
  input  logic [AW-1:0] AD_DMA,
  input  logic          dma_cs,
  output logic [7:0]    DD_DMA,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic          drain_err
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          force_grant;
  logic          dma_rd_q;

  // Last DRAIN tick the CPU is allowed before the grant is forced.
  assign force_grant = (state == DRAIN) && !busrq_n && !cpu_mreq_n &&
                       (cnt == CW'(DRAIN_MAX - 1));

  // State register; only advances on CPU clock enables.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; holds between enables.
  always_comb begin
    state_nx = state;
    if (cpu_cen) begin
      case (state)
        IDLE:    if (!busrq_n) state_nx = DRAIN;
        DRAIN: begin
          if (busrq_n)                        state_nx = IDLE;
          else if (cpu_mreq_n || force_grant) state_nx = GRANT;
        end
        GRANT:   if (busrq_n) state_nx = RELEASE;
        RELEASE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Handshake outputs registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busak_n     <= 1'b1;
      cpu_busrq_n <= 1'b1;
    end else begin
      busak_n     <= (state_nx != GRANT);
      cpu_busrq_n <= (state_nx == IDLE);
    end
  end

  // Drain watchdog: counts enables spent in DRAIN, sticky error on overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      drain_err <= 1'b0;
    end else if (cpu_cen) begin
      if (state == DRAIN && state_nx == DRAIN) cnt <= cnt + 1'b1;
      else                                     cnt <= '0;
      if (force_grant) drain_err <= 1'b1;
    end
  end

  // RAM mux: DMA owns the address in GRANT and CPU writes are dropped there.
  always_comb begin
    ram_din  = cpu_dout;
    ram_addr = cpu_addr;
    ram_we   = 1'b0;
    if (state == GRANT) begin
      ram_addr = AD_DMA;
    end else begin
      ram_we = !rst && cpu_ram_cs && !cpu_mreq_n && !cpu_wr_n;
    end
  end

  // DMA read data: RAM answers one clk after the address, then registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_rd_q <= 1'b0;
      DD_DMA   <= 8'h00;
    end else begin
      dma_rd_q <= (state == GRANT) && dma_cs;
      if (dma_rd_q) DD_DMA <= ram_dout;
    end
  end

endmodule

// File: tb/tb_jtpopeye_busarb.sv
// Bench for jtpopeye_busarb: two instances share stimulus, one with a
// short drain limit to exercise the forced grant.
module tb_jtpopeye_busarb;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, cpu_cen, busrq_n, cpu_mreq_n, cpu_ram_cs, cpu_wr_n, dma_cs;
  logic [AW-1:0] cpu_addr, AD_DMA;
  logic [7:0]    cpu_dout;
  logic          busak_n, cpu_busrq_n, ram_we, drain_err;
  logic [7:0]    DD_DMA, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic          busak_n2, cpu_busrq_n2, ram_we2, drain_err2;
  logic [7:0]    DD_DMA2, ram_din2;
  logic [AW-1:0] ram_addr2;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] exp_q [$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  jtpopeye_busarb #(.AW(AW), .DRAIN_MAX(8)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .busrq_n(busrq_n), .busak_n(busak_n),
    .cpu_mreq_n(cpu_mreq_n), .cpu_ram_cs(cpu_ram_cs), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_busrq_n(cpu_busrq_n),
    .AD_DMA(AD_DMA), .dma_cs(dma_cs), .DD_DMA(DD_DMA), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout), .drain_err(drain_err));

  jtpopeye_busarb #(.AW(AW), .DRAIN_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .busrq_n(busrq_n), .busak_n(busak_n2),
    .cpu_mreq_n(cpu_mreq_n), .cpu_ram_cs(1'b0), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_busrq_n(cpu_busrq_n2),
    .AD_DMA(AD_DMA), .dma_cs(dma_cs), .DD_DMA(DD_DMA2), .ram_addr(ram_addr2),
    .ram_we(ram_we2), .ram_din(ram_din2), .ram_dout(8'h00), .drain_err(drain_err2));

  // Object RAM: synchronous write, one-clk read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One CPU enable tick plus one idle clk; returns at a negedge.
  task automatic tick();
    cpu_cen = 1'b1;
    @(negedge clk);
    cpu_cen = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] e;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'(i);
    mem[10'h155] = 8'hA5;
    rst = 1'b1; cpu_cen = 1'b0; busrq_n = 1'b1; cpu_mreq_n = 1'b1;
    cpu_ram_cs = 1'b0; cpu_wr_n = 1'b1; cpu_addr = 10'h020; cpu_dout = 8'h00;
    AD_DMA = 10'h000; dma_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busak", busak_n, 1);
    chk("rst_cpubusrq", cpu_busrq_n, 1);
    chk("rst_dd", DD_DMA, 8'h00);
    chk("rst_err", drain_err, 0);
    chk("rst_we", ram_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // Idle CPU: stall after 1 tick, grant after 2.
    busrq_n = 1'b0;
    tick();
    chk("t1_cpubusrq", cpu_busrq_n, 0);
    chk("t1_busak_hi", busak_n, 1);
    tick();
    chk("t2_busak", busak_n, 0);
    chk("t2_busak2", busak_n2, 0);

    // DMA read in GRANT with a competing CPU write to the same address.
    AD_DMA = 10'h155; dma_cs = 1'b1;
    cpu_addr = 10'h155; cpu_dout = 8'h5A; cpu_ram_cs = 1'b1; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    exp_q.push_back(8'hA5);
    #1;
    chk("g_addr", ram_addr, 10'h155);
    chk("g_we", ram_we, 0);
    @(negedge clk);
    dma_cs = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("g_dd", DD_DMA, e);
    chk("g_mem", mem[10'h155], 8'hA5);
    cpu_ram_cs = 1'b0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1; cpu_addr = 10'h020;

    // Release: ack drops on first tick, stall lifts one tick later.
    busrq_n = 1'b1;
    tick();
    chk("r_busak", busak_n, 1);
    chk("r_cpubusrq_lo", cpu_busrq_n, 0);
    chk("r_addr_cpu", ram_addr, 10'h020);
    tick();
    chk("r_cpubusrq_hi", cpu_busrq_n, 1);

    // CPU write lands once the bus is back.
    cpu_dout = 8'h3C; cpu_ram_cs = 1'b1; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    exp_q.push_back(8'h3C);
    #1 chk("w_we", ram_we, 1);
    @(negedge clk);
    cpu_ram_cs = 1'b0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    e = exp_q.pop_front();
    chk("w_mem", mem[10'h020], e);

    // Request withdrawn while draining: back to IDLE, never granted.
    busrq_n = 1'b0; cpu_mreq_n = 1'b0;
    tick();
    chk("a_cpubusrq_lo", cpu_busrq_n, 0);
    busrq_n = 1'b1;
    tick();
    chk("a_cpubusrq_hi", cpu_busrq_n, 1);
    chk("a_busak", busak_n, 1);
    tick();
    chk("a_busak2", busak_n, 1);

    // Busy CPU for 3 drain ticks; short-limit instance forces grant on tick 2.
    busrq_n = 1'b0; cpu_mreq_n = 1'b0;
    tick();
    tick();
    chk("d_busak_wait", busak_n, 1);
    chk("d_busak2_wait", busak_n2, 1);
    tick();
    chk("d_force_busak2", busak_n2, 0);
    chk("d_force_err2", drain_err2, 1);
    chk("d_busak_still", busak_n, 1);
    tick();
    chk("d_busak_t4", busak_n, 1);
    cpu_mreq_n = 1'b1;
    tick();
    chk("d_busak_t5", busak_n, 0);
    chk("d_err", drain_err, 0);

    // Reset while granted, with a CPU write strobe active.
    cpu_ram_cs = 1'b1; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("x_busak", busak_n, 1);
    chk("x_cpubusrq", cpu_busrq_n, 1);
    chk("x_dd", DD_DMA, 8'h00);
    chk("x_err2", drain_err2, 0);
    chk("x_we", ram_we, 0);
    rst = 1'b0;
    cpu_ram_cs = 1'b0; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
